// File: rtl/aes_invsub_seq.sv
// Byte-serial AES InvSubBytes (+ optional InvShiftRows) over a 16-byte state buffer.
// Loads 16 bytes, substitutes them in place through a shared S-box, then drains them.
module aes_invsub_seq #(
  parameter int SBOX_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       inv_shift,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic [7:0] sb_x,
  input  logic [7:0] sb_y,
  output logic       busy,
  output logic [1:0] dbg_state
);

  // Handshakes: a byte moves on a rising edge where valid & ready are both high;
  // valid never depends on ready, and a stalled out_valid holds its data unchanged.

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SUB   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [4:0] SUB_LAST = 5'(16 + SBOX_LAT - 1);

  state_t     state, state_d;
  logic [3:0] cnt;
  logic [4:0] sub_k;
  logic       shift_q;
  logic [7:0] buf_q [16];

  logic       in_fire, out_fire;
  logic [3:0] src;
  logic [3:0] wr_idx;
  logic       wr_en;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Result of operand k arrives SBOX_LAT cycles after it was presented.
  assign wr_en  = (state == SUB) && ({1'b0, sub_k} >= 6'(SBOX_LAT));
  assign wr_idx = 4'(sub_k - 5'(SBOX_LAT));

  // InvShiftRows source: same row, column (c - r) mod 4.
  assign src = shift_q ? {cnt[3:2] - cnt[1:0], cnt[1:0]} : cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      cnt     <= 4'd0;
      sub_k   <= 5'd0;
      shift_q <= 1'b0;
    end else begin
      state <= state_d;
      if (flush) begin
        cnt   <= 4'd0;
        sub_k <= 5'd0;
      end else begin
        case (state)
          LOAD: begin
            if (in_fire) begin
              cnt <= cnt + 4'd1;
              if (cnt == 4'd0) shift_q <= inv_shift;
            end
          end
          SUB: begin
            sub_k <= (sub_k == SUB_LAST) ? 5'd0 : sub_k + 5'd1;
          end
          DRAIN: begin
            if (out_fire) cnt <= cnt + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Buffer is data-only storage; it is never cleared.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (state == LOAD && in_fire) buf_q[cnt] <= in_data;
      if (wr_en)                    buf_q[wr_idx] <= sb_y;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      LOAD:    if (in_fire && cnt == 4'd15)  state_d = SUB;
      SUB:     if (sub_k == SUB_LAST)        state_d = DRAIN;
      DRAIN:   if (out_fire && cnt == 4'd15) state_d = LOAD;
      default: state_d = LOAD;
    endcase
    if (flush) state_d = LOAD;
  end

  always_comb begin
    in_ready  = (state == LOAD) && !rst;
    out_valid = (state == DRAIN) && !rst;
    out_data  = out_valid ? buf_q[src] : 8'd0;
    busy      = ((state == SUB) || (state == DRAIN)) && !rst;
    sb_x      = 8'd0;
    if (state == SUB && sub_k < 5'd16 && !rst) sb_x = buf_q[sub_k[3:0]];
    dbg_state = state;
  end

endmodule

// File: tb/tb_aes_invsub_seq.sv
// Randomized and directed bench for aes_invsub_seq with a one-cycle inverse S-box model
// and a queue-based scoreboard of expected output bytes.
module tb_aes_invsub_seq;

  logic       clk = 1'b0;
  logic       rst, flush, inv_shift, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, busy;
  logic [7:0] out_data, sb_x, sb_y, sb_y_q;
  logic [1:0] dbg_state;

  aes_invsub_seq #(.SBOX_LAT(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .inv_shift(inv_shift),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .sb_x(sb_x), .sb_y(sb_y), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- inverse S-box reference (from GF(2^8) math) ----------------
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'd0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] v = 8'd1;
    for (int i = 0; i < 254; i++) v = gmul(v, a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  initial for (int i = 0; i < 256; i++) inv_tab[fwd_sbox(8'(i))] = 8'(i);

  always @(posedge clk) sb_y_q <= inv_tab[sb_x];
  assign sb_y = sb_y_q;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: pops expected bytes on transfers, checks stability over stalls.
  logic       stall_pend = 1'b0;
  logic [7:0] held;
  always @(negedge clk) begin
    if (stall_pend) begin
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_data", {24'd0, out_data}, {24'd0, held});
      stall_pend = 1'b0;
    end
    if (!rst && out_valid) begin
      if (!out_ready) begin
        stall_pend = 1'b1;
        held       = out_data;
      end else if (exp_q.size() == 0) begin
        check("extra_out", {31'd0, out_valid}, 32'd0);
      end else begin
        check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- downstream ready driver ----------------
  logic rand_rdy = 1'b0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- driver tasks / model ----------------
  logic [7:0] blk [16];
  int last_cyc;
  logic [7:0] exp35 [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                             8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
  logic [7:0] vec35 [16] = '{8'h63, 8'h7C, 8'h77, 8'h7B, 8'hF2, 8'h6B, 8'h6F, 8'hC5,
                             8'h30, 8'h01, 8'h67, 8'h2B, 8'hFE, 8'hD7, 8'hAB, 8'h76};

  // Called at #1 after a posedge; leaves time at #1 after the last transfer edge.
  task automatic send_bytes(input int n, input logic shift, input logic flip);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      while (!in_ready && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 200) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid  = 1'b1;
      in_data   = blk[i];
      inv_shift = (flip && i > 0) ? ~shift : shift;
      last_cyc  = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic push_model(input logic shift);
    for (int j = 0; j < 16; j++) begin
      int r = j % 4;
      int c = j / 4;
      int s = shift ? r + 4 * ((c - r + 4) % 4) : j;
      exp_q.push_back(inv_tab[blk[s]]);
    end
  endtask

  task automatic wait_drain(input string tag);
    int guard = 0;
    while ((exp_q.size() != 0 || dbg_state != 2'd0) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check(tag, exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
    check({tag, "_sb_x"}, {24'd0, sb_x}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; inv_shift = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // 0x63 block: all zero results, 18-cycle latency
    for (int i = 0; i < 16; i++) blk[i] = 8'h63;
    send_bytes(16, 1'b0, 1'b0);
    push_model(1'b0);
    @(negedge clk);
    check("sub_busy", {31'd0, busy}, 32'd1);
    check("sub_sb_x0", {24'd0, sb_x}, 32'h63);
    check("sub_in_ready", {31'd0, in_ready}, 32'd0);
    begin
      int guard = 0;
      while (!out_valid && guard < 40) begin
        @(negedge clk);
        guard++;
      end
    end
    check("latency", cyc - last_cyc, 32'd18);
    wait_drain("drain_63");

    // Directed vector with InvShiftRows
    for (int i = 0; i < 16; i++) blk[i] = vec35[i];
    send_bytes(16, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) exp_q.push_back(exp35[i]);
    wait_drain("drain_shift");

    // Same vector, no shift, inv_shift toggled after byte 0
    send_bytes(16, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    wait_drain("drain_noshift");

    // 0x16 block with random back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 16; i++) blk[i] = 8'h16;
    send_bytes(16, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'hFF);
    wait_drain("drain_stall");
    rand_rdy = 1'b0;

    // Flush after 7 bytes, coincident with an input transfer
    for (int i = 0; i < 16; i++) blk[i] = 8'($urandom_range(0, 255));
    send_bytes(7, 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 8'hAA; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_idle("flush");
    check("flush_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) blk[i] = 8'h00;
    send_bytes(16, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h52);
    wait_drain("drain_flush");

    // Reset in SUB cycle 5, then a clean 0x7C block
    for (int i = 0; i < 16; i++) blk[i] = 8'($urandom_range(0, 255));
    send_bytes(16, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_idle("midrst");
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_state", {30'd0, dbg_state}, 32'd0);
    check_idle("midrst_held");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready_after", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) blk[i] = 8'h7C;
    send_bytes(16, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h01);
    wait_drain("drain_7c");

    // Random blocks, random shift, random back-pressure
    rand_rdy = 1'b1;
    for (int b = 0; b < 5; b++) begin
      logic sh = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) blk[i] = 8'($urandom_range(0, 255));
      send_bytes(16, sh, 1'b0);
      push_model(sh);
      wait_drain("drain_rand");
    end
    rand_rdy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
